// File: rtl/jbi_sctag_pkg.sv
// Shared definitions for the JBI-to-sctag ingress queue: command encodings,
// internal request types, per-type beat counts and the assembly FSM states.
package jbi_sctag_pkg;

  // beat0[31:29] command encodings
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_WRI = 3'b010;
  localparam logic [2:0] CMD_WR8 = 3'b100;

  // Data beats of an 8-byte write; a line write uses the DATA_BEATS parameter
  localparam int unsigned WR8_BEATS = 2;

  typedef enum logic [1:0] {
    TypeRd  = 2'b00,
    TypeWri = 2'b01,
    TypeWr8 = 2'b10
  } req_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } deser_state_e;

  function automatic logic cmd_valid(input logic [2:0] cmd);
    return (cmd == CMD_RD) || (cmd == CMD_WRI) || (cmd == CMD_WR8);
  endfunction

  function automatic req_type_e cmd_to_type(input logic [2:0] cmd);
    case (cmd)
      CMD_WRI: return TypeWri;
      CMD_WR8: return TypeWr8;
      default: return TypeRd;
    endcase
  endfunction

endpackage

// File: rtl/sctag_jbi_iq_deser_if.sv
// Request-stream and IQ-consumer signals of the sctag ingress deserializer.
// master: the JBI stream source / IQ consumer side; slave: the deserializer.
interface sctag_jbi_iq_deser_if #(
  parameter int unsigned DATA_BEATS = 16
);
  logic [31:0]              jbi_sctag_req_d1;
  logic                     jbi_sctag_req_vld_d1;
  logic                     iq_req_vld;
  logic                     iq_req_rdy;
  logic [63:0]              iq_req_hdr;
  logic [32*DATA_BEATS-1:0] iq_req_data;
  logic [1:0]               iq_req_type;
  logic                     sctag_jbi_iq_dequeue;

  modport master (
    output jbi_sctag_req_d1, jbi_sctag_req_vld_d1, iq_req_rdy,
    input  iq_req_vld, iq_req_hdr, iq_req_data, iq_req_type, sctag_jbi_iq_dequeue
  );

  modport slave (
    input  jbi_sctag_req_d1, jbi_sctag_req_vld_d1, iq_req_rdy,
    output iq_req_vld, iq_req_hdr, iq_req_data, iq_req_type, sctag_jbi_iq_dequeue
  );
endinterface

// File: rtl/sctag_jbi_iq_fifo.sv
// Small synchronous FIFO with valid/ready read side. A pop in the same cycle
// as a push into a full FIFO frees the slot, so the push is accepted.
module sctag_jbi_iq_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             pop, push_ok;

  assign out_vld  = (count_q != '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign pop      = out_vld & out_rdy;
  assign push_ok  = push & (~full | pop);
  assign out_data = mem_q[rd_ptr_q];

  // Storage, pointers (wrap naturally, depth is a power of two) and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sctag_jbi_iq_deser.sv
// Sctag ingress for JBI requests: assembles header, address and data beats
// into one entry, queues it, and returns a dequeue credit per consumed entry.
module sctag_jbi_iq_deser
  import jbi_sctag_pkg::*;
#(
  parameter int unsigned IQ_DEPTH   = 2,
  parameter int unsigned DATA_BEATS = 16
) (
  input  logic                rclk,
  input  logic                arst_l,
  sctag_jbi_iq_deser_if.slave iq,
  output logic                iq_ovf_err,
  output logic                iq_proto_err
);
  localparam int unsigned DW     = 32 * DATA_BEATS;
  localparam int unsigned CntW   = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam int unsigned EntryW = 2 + 64 + DW;

  deser_state_e     state_q;
  req_type_e        type_q, beat0_type;
  logic [31:0]      hdr0_q, hdr1_q;
  logic [DW-1:0]    data_q, data_ins;
  logic [CntW-1:0]  cnt_q, last_q, beat0_last;
  logic             deq_q, ovf_q, proto_q;
  logic [31:0]      beat;
  logic             beat_vld, beat0_ok;
  logic             commit, drop, pop, fifo_full;
  logic [EntryW-1:0] push_entry, head_entry;

  assign beat       = iq.jbi_sctag_req_d1;
  assign beat_vld   = iq.jbi_sctag_req_vld_d1;
  assign beat0_ok   = cmd_valid(beat[31:29]);
  assign beat0_type = cmd_to_type(beat[31:29]);
  assign pop        = iq.iq_req_vld & iq.iq_req_rdy;
  assign drop       = commit & fifo_full & ~pop;

  // Decode the commit point and build the entry from staged fields plus the live beat
  always_comb begin
    data_ins = data_q;
    data_ins[32*cnt_q +: 32] = beat;
    beat0_last = '0;
    case (beat0_type)
      TypeWri: beat0_last = CntW'(DATA_BEATS - 1);
      TypeWr8: beat0_last = CntW'(WR8_BEATS - 1);
      default: beat0_last = '0;
    endcase
    commit     = 1'b0;
    push_entry = {type_q, hdr0_q, beat, data_q};
    // A header arriving mid-request abandons the partial entry
    if (!beat_vld) begin
      if (state_q == StAddr && type_q == TypeRd) begin
        commit = 1'b1;
      end else if (state_q == StData && cnt_q == last_q) begin
        commit     = 1'b1;
        push_entry = {type_q, hdr0_q, hdr1_q, data_ins};
      end
    end
  end

  // Assembly FSM, staging registers, sticky errors and dequeue credit
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= StIdle;
      type_q  <= TypeRd;
      hdr0_q  <= '0;
      hdr1_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      deq_q   <= 1'b0;
      ovf_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      deq_q <= pop;
      if (drop) ovf_q <= 1'b1;
      if (beat_vld) begin
        if (state_q != StIdle) proto_q <= 1'b1;
        if (beat0_ok) begin
          hdr0_q  <= beat;
          type_q  <= beat0_type;
          data_q  <= '0;
          cnt_q   <= '0;
          last_q  <= beat0_last;
          state_q <= StAddr;
        end else begin
          proto_q <= 1'b1;
          state_q <= StIdle;
        end
      end else begin
        unique case (state_q)
          StIdle: ;
          StAddr: begin
            hdr1_q  <= beat;
            cnt_q   <= '0;
            state_q <= (type_q == TypeRd) ? StIdle : StData;
          end
          StData: begin
            data_q <= data_ins;
            cnt_q  <= cnt_q + CntW'(1);
            if (cnt_q == last_q) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  sctag_jbi_iq_fifo #(
    .WIDTH (EntryW),
    .DEPTH (IQ_DEPTH)
  ) u_fifo (
    .clk       (rclk),
    .rst_n     (arst_l),
    .push      (commit),
    .push_data (push_entry),
    .full      (fifo_full),
    .out_vld   (iq.iq_req_vld),
    .out_rdy   (iq.iq_req_rdy),
    .out_data  (head_entry)
  );

  assign iq.iq_req_type          = head_entry[EntryW-1 -: 2];
  assign iq.iq_req_hdr           = head_entry[DW +: 64];
  assign iq.iq_req_data          = head_entry[DW-1:0];
  assign iq.sctag_jbi_iq_dequeue = deq_q;
  assign iq_ovf_err              = ovf_q;
  assign iq_proto_err            = proto_q;

endmodule

// File: tb/tb_sctag_jbi_iq_deser.sv
// Bench for sctag_jbi_iq_deser: directed scenarios followed by random request
// traffic, compared every cycle against a transaction-level queue model.
module tb_sctag_jbi_iq_deser;
  localparam int unsigned IQ_DEPTH   = 2;
  localparam int unsigned DATA_BEATS = 16;
  localparam int unsigned DW         = 32 * DATA_BEATS;
  localparam logic [1:0]  RD = 2'b00, WRI = 2'b01, WR8 = 2'b10;

  typedef struct packed {
    logic [1:0]    t;
    logic [63:0]   hdr;
    logic [DW-1:0] data;
  } entry_t;

  logic rclk   = 1'b0;
  logic arst_l = 1'b0;
  logic iq_ovf_err, iq_proto_err;

  sctag_jbi_iq_deser_if #(.DATA_BEATS(DATA_BEATS)) iface ();

  sctag_jbi_iq_deser #(
    .IQ_DEPTH   (IQ_DEPTH),
    .DATA_BEATS (DATA_BEATS)
  ) dut (
    .rclk         (rclk),
    .arst_l       (arst_l),
    .iq           (iface),
    .iq_ovf_err   (iq_ovf_err),
    .iq_proto_err (iq_proto_err)
  );

  always #5 rclk = ~rclk;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];
  logic   exp_ovf = 1'b0, exp_proto = 1'b0, exp_deq = 1'b0;
  bit     pending_partial = 1'b0;
  bit     rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".vld"}, iface.iq_req_vld, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk({where, ".type"}, iface.iq_req_type, exp_q[0].t);
      chk({where, ".hdr"}, iface.iq_req_hdr, exp_q[0].hdr);
      chk({where, ".data"}, iface.iq_req_data, exp_q[0].data);
    end
    chk({where, ".deq"}, iface.sctag_jbi_iq_dequeue, exp_deq);
    chk({where, ".ovf"}, iq_ovf_err, exp_ovf);
    chk({where, ".proto"}, iq_proto_err, exp_proto);
  endtask

  // One clock of stream input; the model applies pop then commit at the edge
  task automatic beat(input logic [31:0] b, input logic v, input logic commit, input entry_t e);
    bit pop;
    iface.jbi_sctag_req_d1     = b;
    iface.jbi_sctag_req_vld_d1 = v;
    if (rand_rdy) iface.iq_req_rdy = 1'($urandom_range(0, 1));
    @(posedge rclk);
    pop = (exp_q.size() > 0) && iface.iq_req_rdy;
    if (pop) void'(exp_q.pop_front());
    if (commit) begin
      if (exp_q.size() < IQ_DEPTH) exp_q.push_back(e);
      else exp_ovf = 1'b1;
    end
    exp_deq = pop;
    #1;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat($urandom, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [2:0] cmd_of(input logic [1:0] t);
    return (t == RD) ? 3'b001 : (t == WRI) ? 3'b010 : 3'b100;
  endfunction

  // trunc > 0 sends only that many beats, leaving the request unfinished
  task automatic send_req(input logic [1:0] t, input logic [28:0] tag, input logic [31:0] addr,
                          input logic [DW-1:0] d, input int trunc, input bit last_rdy);
    int          nd, total, n;
    entry_t      e;
    logic [31:0] b0, b;
    nd    = (t == RD) ? 0 : (t == WRI) ? DATA_BEATS : 2;
    total = 2 + nd;
    b0    = {cmd_of(t), tag};
    e.t   = t;
    e.hdr = {b0, addr};
    e.data = '0;
    for (int k = 0; k < nd; k++) e.data[32*k +: 32] = d[32*k +: 32];
    if (pending_partial) exp_proto = 1'b1;
    n = (trunc > 0) ? trunc : total;
    for (int i = 0; i < n; i++) begin
      if (i == 0) b = b0;
      else if (i == 1) b = addr;
      else b = d[32*(i-2) +: 32];
      if (last_rdy && i == total - 1) iface.iq_req_rdy = 1'b1;
      beat(b, i == 0, (i == total - 1) && (trunc == 0), e);
    end
    pending_partial = (trunc > 0);
  endtask

  task automatic send_reserved(input logic [2:0] cmd, input logic [28:0] tag);
    exp_proto = 1'b1;
    beat({cmd, tag}, 1'b1, 1'b0, '0);
    pending_partial = 1'b0;
  endtask

  task automatic drain_count(input int n, output int pulses);
    pulses = 0;
    iface.iq_req_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (iface.sctag_jbi_iq_dequeue) pulses++;
    end
    iface.iq_req_rdy = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    t;
    int            pulses, r, nd, tr;
    logic [2:0]    rsv;

    iface.jbi_sctag_req_d1     = '0;
    iface.jbi_sctag_req_vld_d1 = 1'b0;
    iface.iq_req_rdy           = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst.vld", iface.iq_req_vld, 1'b0);
    chk("rst.hdr", iface.iq_req_hdr, 64'h0);
    chk("rst.data", iface.iq_req_data, '0);
    chk("rst.type", iface.iq_req_type, 2'b00);
    chk("rst.deq", iface.sctag_jbi_iq_dequeue, 1'b0);
    chk("rst.ovf", iq_ovf_err, 1'b0);
    chk("rst.proto", iq_proto_err, 1'b0);
    @(negedge rclk);
    arst_l = 1'b1;

    // RD: visible right after the address beat, one credit after the pop
    send_req(RD, 29'h0A5, 32'h0000_1F40, '0, 0, 1'b0);
    chk("rd.hdr", iface.iq_req_hdr, 64'h200000A5_00001F40);
    chk("rd.type", iface.iq_req_type, 2'b00);
    chk("rd.data", iface.iq_req_data, '0);
    iface.iq_req_rdy = 1'b1;
    idle(1);
    chk("rd.deq1", iface.sctag_jbi_iq_dequeue, 1'b1);
    idle(1);
    chk("rd.deq0", iface.sctag_jbi_iq_dequeue, 1'b0);
    iface.iq_req_rdy = 1'b0;

    // WRI with beat k = 0x100+k
    for (int k = 0; k < DATA_BEATS; k++) d[32*k +: 32] = 32'h100 + k;
    send_req(WRI, 29'h0ABC, 32'h0000_4000, d, 0, 1'b0);
    chk("wri.beat5", iface.iq_req_data[32*5 +: 32], 32'h105);
    chk("wri.beat15", iface.iq_req_data[32*15 +: 32], 32'h10F);
    chk("wri.type", iface.iq_req_type, 2'b01);
    drain_count(2, pulses);

    // WR8 keeps only two data beats
    d = '1;
    d[63:0] = 64'h12345678_DEADBEEF;
    send_req(WR8, 29'h0123, 32'h0000_8008, d, 0, 1'b0);
    chk("wr8.data", iface.iq_req_data, {{(DW-64){1'b0}}, 64'h12345678_DEADBEEF});
    chk("wr8.type", iface.iq_req_type, 2'b10);
    drain_count(2, pulses);

    // Full FIFO, commit coincides with pop: no overflow, two entries remain
    send_req(RD, 29'h1, 32'h10, '0, 0, 1'b0);
    send_req(RD, 29'h2, 32'h20, '0, 0, 1'b0);
    send_req(RD, 29'h3, 32'h30, '0, 0, 1'b1);
    chk("fullpop.ovf", iq_ovf_err, 1'b0);
    drain_count(3, pulses);
    chk("fullpop.pulses", pulses, 2);

    // Overflow: third RD dropped
    send_req(RD, 29'h4, 32'h40, '0, 0, 1'b0);
    send_req(RD, 29'h5, 32'h50, '0, 0, 1'b0);
    send_req(RD, 29'h6, 32'h60, '0, 0, 1'b0);
    chk("ovf.flag", iq_ovf_err, 1'b1);
    drain_count(3, pulses);
    chk("ovf.pulses", pulses, 2);

    // Header during WRI data phase: WRI abandoned, new request assembled
    send_req(WRI, 29'h77, 32'h700, d, 6, 1'b0);
    send_req(RD, 29'h88, 32'h800, '0, 0, 1'b0);
    chk("proto.flag", iq_proto_err, 1'b1);
    chk("proto.hdr", iface.iq_req_hdr, 64'h20000088_00000800);
    drain_count(2, pulses);
    chk("proto.pulses", pulses, 1);

    // Random traffic with random ready
    rand_rdy = 1'b1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0 && !pending_partial) begin
        case ($urandom_range(0, 4))
          0:       rsv = 3'b000;
          1:       rsv = 3'b011;
          2:       rsv = 3'b101;
          3:       rsv = 3'b110;
          default: rsv = 3'b111;
        endcase
        send_reserved(rsv, 29'($urandom));
      end else begin
        t = 2'($urandom_range(0, 2));
        for (int k = 0; k < DATA_BEATS; k++) d[32*k +: 32] = $urandom;
        nd = (t == RD) ? 0 : (t == WRI) ? DATA_BEATS : 2;
        tr = (r == 1) ? $urandom_range(1, 1 + nd) : 0;
        send_req(t, 29'($urandom), $urandom, d, tr, 1'b0);
      end
      if (!pending_partial) idle($urandom_range(0, 2));
    end
    if (pending_partial) send_req(RD, 29'h9, 32'h90, '0, 0, 1'b0);
    rand_rdy = 1'b0;
    iface.iq_req_rdy = 1'b0;
    idle(2);

    // Reset mid-request clears queue, errors and outputs
    send_req(RD, 29'hA, 32'hA0, '0, 0, 1'b0);
    send_req(WRI, 29'hB, 32'hB0, d, 5, 1'b0);
    arst_l = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_proto = 1'b0;
    exp_deq = 1'b0;
    pending_partial = 1'b0;
    chk("arst.vld", iface.iq_req_vld, 1'b0);
    chk("arst.hdr", iface.iq_req_hdr, 64'h0);
    chk("arst.data", iface.iq_req_data, '0);
    chk("arst.type", iface.iq_req_type, 2'b00);
    chk("arst.ovf", iq_ovf_err, 1'b0);
    chk("arst.proto", iq_proto_err, 1'b0);
    @(negedge rclk);
    arst_l = 1'b1;
    idle(3);
    send_req(WR8, 29'hC, 32'hC0, d, 0, 1'b0);
    drain_count(2, pulses);
    chk("post_rst.pulses", pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
